plic_axi4_slave_port: RTL and testbench
=======================================

Name: plic_axi4_slave_port

Overview:
AXI4 (full) slave responder for the ariane_plic S00_AXI port. It terminates the burst traffic issued by the system master, which in simulation is the AXI VIP master agent. It accepts INCR, FIXED and WRAP bursts of 32-bit beats and stores them in an internal word-addressed register bank. It returns the stored data on read bursts. The PLIC core samples the bank through a read-only side port.

Parameters:
C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
C_S_AXI_ADDR_WIDTH, 6, byte address width; bank depth = 2**(C_S_AXI_ADDR_WIDTH-2) words (16)

Ports:
ACLK  in  1  sole clock, rising edge
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address channel
S_AXI_AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION  in  1/4/3/4/4  accepted, ignored
S_AXI_AWVALID  in  1 ; S_AXI_AWREADY  out  1  AW handshake
S_AXI_WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1 ; S_AXI_WREADY  out  1  write data channel
S_AXI_BID/BRESP/BVALID  out  ID/2/1 ; S_AXI_BREADY  in  1  write response channel
S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address channel
S_AXI_ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION  in  1/4/3/4/4  accepted, ignored
S_AXI_ARVALID  in  1 ; S_AXI_ARREADY  out  1  AR handshake
S_AXI_RID/RDATA/RRESP/RLAST/RVALID  out  ID/32/2/1/1 ; S_AXI_RREADY  in  1  read data channel
reg_bank_o  out  32*depth  flattened bank contents, word 0 in LSBs

Behaviour:
- Reset, asynchronous on ARESETN=0: state IDLE. AWREADY, WREADY, ARREADY, BVALID, RVALID and RLAST = 0. BRESP, RRESP, RDATA, BID, RID = 0. All bank words = 0.
- Reset mid-burst aborts the burst immediately. No partial-response obligations remain after release.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA. One transaction is outstanding at a time.
- IDLE:
  - AWREADY = 1.
  - ARREADY = !AWVALID, so a write wins a simultaneous request.
  - AW handshake latches ID, ADDR, LEN, SIZE and BURST, clears the beat counter and moves to WR_DATA.
  - AR handshake latches the same fields and moves to RD_DATA.
- WR_DATA:
  - WREADY = 1, starting the cycle after the AW handshake.
  - Each W handshake writes bank[addr[ADDR-1:2]] byte-wise per WSTRB, then advances the address and counter.
  - The beat with counter == LEN is the final beat; the FSM then moves to WR_RESP.
  - Exactly LEN+1 beats are always consumed.
- WR_RESP:
  - BVALID rises the cycle after the final W beat. BID = latched ID.
  - BVALID is held until BREADY, then the FSM returns to IDLE.
  - No new AW is accepted in the BREADY cycle.
- BRESP = SLVERR (2'b10) when any of these occurs:
  - AWSIZE != 2;
  - AWBURST = 2'b11;
  - WRAP with LEN not in {1, 3, 7, 15};
  - WLAST is high before the final beat, or low on the final beat.
- In the first three SLVERR cases all bank writes for the burst are suppressed. A WLAST mismatch does not suppress writes.
- RD_DATA:
  - RVALID rises the cycle after the AR handshake. RDATA = bank[addr] (registered). RID = latched ID.
  - RLAST = 1 on the beat with counter == LEN.
  - RDATA, RRESP and RLAST are stable while RVALID && !RREADY.
  - With RREADY held high, one beat is returned per cycle.
  - The FSM returns to IDLE after the RLAST handshake.
  - Illegal SIZE, BURST or WRAP length returns LEN+1 beats with RDATA = 0 and RRESP = SLVERR.
- Address generation, byte address:
  - INCR: +4 per beat, modulo bank size.
  - FIXED: unchanged.
  - WRAP: boundary = floor(addr / ((LEN+1)*4)) * (LEN+1)*4; on reaching boundary + (LEN+1)*4 the address returns to the boundary.
  - Low two address bits are ignored.
- Width rules: beat counter is 8 bits, so LEN = 255 is legal. It has no wrap-around issue because the counter compares against LEN.
- reg_bank_o reflects a write the cycle after the W handshake.

Decomposition:
- Package plic_axi_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - BURST_FIXED, BURST_INCR and BURST_WRAP codes;
  - the state enum type;
  - a pure function checking burst legality.
- Sub-module axi_burst_addr_gen computes the next address from addr, len and burst. It is instantiated once each for the write and read paths.

Test Plan:
- INCR write, LEN=7, ADDR=0, data 1..8, then INCR read of the same range -> BRESP=00; RDATA 1..8; RLAST only on beat 8; BVALID one cycle after the last W beat.
- Partial-strobe write -> bank[4]=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0011 at 0x10 -> read returns 0x1122CCDD.
- WRAP write, LEN=3, ADDR=0x08, data A,B,C,D -> bank[2]=A, bank[3]=B, bank[0]=C, bank[1]=D; a WRAP read at 0x08 returns A,B,C,D.
- AWVALID and ARVALID raised together in IDLE -> AW accepted first. ARREADY stays low until BVALID&&BREADY completes, then AR is accepted and returns the post-write data.
- RREADY toggling 1,0,1,0 during an 8-beat read -> RDATA/RLAST held during stall cycles; beats arrive in order; 8 handshakes total.
- Error cases, each checked separately:
  - AWSIZE=1 -> BRESP=10 and bank unchanged.
  - WLAST on beat 3 of LEN=7 -> BRESP=10, and 8 beats are still consumed.
  - ARESETN pulsed low mid-read -> RVALID=0 and bank=0 immediately.

Source files
------------

// File: rtl/plic_axi_pkg.sv
// Shared codes, FSM state type and burst-legality check for the PLIC AXI4 slave port.
package plic_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_DATA
  } state_e;

  // Only 32-bit beats, no reserved burst code, and WRAP lengths of 2/4/8/16 beats.
  function automatic logic burst_legal(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size == 3'd2) && (burst != 2'b11) && ((burst != BURST_WRAP) || wrap_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for FIXED/INCR/WRAP bursts over a word-addressed bank.
module axi_burst_addr_gen
  import plic_axi_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  localparam int WW = ADDR_W - 2;

  logic [WW-1:0] word;
  logic [WW-1:0] inc;
  logic [WW-1:0] mask;
  logic [WW-1:0] nxt;

  // Legal wrap lengths are powers of two, so LEN itself is the in-window word mask.
  always_comb begin
    word = addr_i[ADDR_W-1:2];
    inc  = word + WW'(1);
    mask = len_i[WW-1:0];
    case (burst_i)
      BURST_INCR: nxt = inc;
      BURST_WRAP: nxt = (word & ~mask) | (inc & mask);
      default:    nxt = word;
    endcase
    next_addr_o = {nxt, 2'b00};
  end

  logic unused_ok;
  assign unused_ok = ^{addr_i[1:0], len_i[7:WW]};

endmodule

// File: rtl/plic_axi4_slave_port.sv
// AXI4 burst slave terminating the S00_AXI port into a word register bank,
// with the whole bank exposed read-only to the PLIC core.
module plic_axi4_slave_port
  import plic_axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
  input  logic [7:0]                            S_AXI_AWLEN,
  input  logic [2:0]                            S_AXI_AWSIZE,
  input  logic [1:0]                            S_AXI_AWBURST,
  input  logic                                  S_AXI_AWLOCK,
  input  logic [3:0]                            S_AXI_AWCACHE,
  input  logic [2:0]                            S_AXI_AWPROT,
  input  logic [3:0]                            S_AXI_AWQOS,
  input  logic [3:0]                            S_AXI_AWREGION,
  input  logic                                  S_AXI_AWVALID,
  output logic                                  S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
  input  logic                                  S_AXI_WLAST,
  input  logic                                  S_AXI_WVALID,
  output logic                                  S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_BID,
  output logic [1:0]                            S_AXI_BRESP,
  output logic                                  S_AXI_BVALID,
  input  logic                                  S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
  input  logic [7:0]                            S_AXI_ARLEN,
  input  logic [2:0]                            S_AXI_ARSIZE,
  input  logic [1:0]                            S_AXI_ARBURST,
  input  logic                                  S_AXI_ARLOCK,
  input  logic [3:0]                            S_AXI_ARCACHE,
  input  logic [2:0]                            S_AXI_ARPROT,
  input  logic [3:0]                            S_AXI_ARQOS,
  input  logic [3:0]                            S_AXI_ARREGION,
  input  logic                                  S_AXI_ARVALID,
  output logic                                  S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]           S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
  output logic [1:0]                            S_AXI_RRESP,
  output logic                                  S_AXI_RLAST,
  output logic                                  S_AXI_RVALID,
  input  logic                                  S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*(2**(C_S_AXI_ADDR_WIDTH-2))-1:0] reg_bank_o
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int DEPTH = 2 ** (AW - 2);

  state_e                      state_q, state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q;
  logic [AW-1:0]               wr_addr_q, rd_addr_q, wr_next, rd_next;
  logic [7:0]                  len_q, cnt_q;
  logic [1:0]                  burst_q, bresp_q, rresp_q;
  logic                        err_q, wlast_err_q, rlast_q;
  logic [DW-1:0]               rdata_q;
  logic [DW-1:0]               bank_q [DEPTH];
  logic                        awready, arready, wready;
  logic                        aw_hs, ar_hs, w_hs, r_hs, last_beat, wlast_bad;

  axi_burst_addr_gen #(.ADDR_W(AW)) u_wr_gen (
    .addr_i(wr_addr_q), .len_i(len_q), .burst_i(burst_q), .next_addr_o(wr_next)
  );
  axi_burst_addr_gen #(.ADDR_W(AW)) u_rd_gen (
    .addr_i(rd_addr_q), .len_i(len_q), .burst_i(burst_q), .next_addr_o(rd_next)
  );

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    case (state_q)
      IDLE: begin
        awready = 1'b1;
        arready = !S_AXI_AWVALID;
        if (S_AXI_AWVALID)      state_d = WR_DATA;
        else if (S_AXI_ARVALID) state_d = RD_DATA;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (S_AXI_WVALID && last_beat) state_d = WR_RESP;
      end
      WR_RESP: if (S_AXI_BREADY) state_d = IDLE;
      RD_DATA: if (S_AXI_RREADY && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign last_beat = (cnt_q == len_q);
  assign wlast_bad = (S_AXI_WLAST != last_beat);
  assign aw_hs     = (state_q == IDLE) && S_AXI_AWVALID;
  assign ar_hs     = (state_q == IDLE) && !S_AXI_AWVALID && S_AXI_ARVALID;
  assign w_hs      = (state_q == WR_DATA) && S_AXI_WVALID;
  assign r_hs      = (state_q == RD_DATA) && S_AXI_RREADY;

  // Readies are held low while reset is asserted even though the state already reads IDLE.
  assign S_AXI_AWREADY = awready && ARESETN;
  assign S_AXI_ARREADY = arready && ARESETN;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = (state_q == WR_RESP);
  assign S_AXI_BID     = id_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (state_q == RD_DATA);
  assign S_AXI_RID     = id_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      id_q <= '0; wr_addr_q <= '0; rd_addr_q <= '0; len_q <= '0; cnt_q <= '0;
      burst_q <= '0; err_q <= 1'b0; wlast_err_q <= 1'b0;
      bresp_q <= RESP_OKAY; rresp_q <= RESP_OKAY; rdata_q <= '0; rlast_q <= 1'b0;
    end else begin
      if (aw_hs) begin
        id_q        <= S_AXI_AWID;
        wr_addr_q   <= S_AXI_AWADDR;
        len_q       <= S_AXI_AWLEN;
        burst_q     <= S_AXI_AWBURST;
        err_q       <= !burst_legal(S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLEN);
        cnt_q       <= '0;
        wlast_err_q <= 1'b0;
      end else if (ar_hs) begin
        id_q      <= S_AXI_ARID;
        rd_addr_q <= S_AXI_ARADDR;
        len_q     <= S_AXI_ARLEN;
        burst_q   <= S_AXI_ARBURST;
        cnt_q     <= '0;
        rlast_q   <= (S_AXI_ARLEN == 8'd0);
        if (burst_legal(S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN)) begin
          err_q   <= 1'b0;
          rresp_q <= RESP_OKAY;
          rdata_q <= bank_q[S_AXI_ARADDR[AW-1:2]];
        end else begin
          err_q   <= 1'b1;
          rresp_q <= RESP_SLVERR;
          rdata_q <= '0;
        end
      end
      if (w_hs) begin
        wr_addr_q <= wr_next;
        cnt_q     <= cnt_q + 8'd1;
        if (wlast_bad) wlast_err_q <= 1'b1;
        if (last_beat) bresp_q <= (err_q || wlast_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
      end
      // Next beat is fetched on the handshake so RDATA stays put through stalls.
      if (r_hs) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          rd_addr_q <= rd_next;
          cnt_q     <= cnt_q + 8'd1;
          rlast_q   <= ((cnt_q + 8'd1) == len_q);
          rdata_q   <= err_q ? '0 : bank_q[rd_next[AW-1:2]];
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (w_hs && !err_q) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (S_AXI_WSTRB[b]) bank_q[wr_addr_q[AW-1:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign reg_bank_o[DW*g +: DW] = bank_q[g];
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
                       S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
                       wr_next[1:0], rd_next[1:0]};

endmodule

// File: tb/tb_plic_axi4_slave_port.sv
// Directed bench for plic_axi4_slave_port: single-beat vector table plus burst sequences.
module tb_plic_axi4_slave_port;
  import plic_axi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        awid, awvalid, awready, wlast, wvalid, wready, bid, bvalid, bready;
  logic [5:0]  awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        arid, arvalid, arready, rid, rlast, rvalid, rready;
  logic [511:0] bank;

  plic_axi4_slave_port dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
    .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
    .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_bank_o(bank)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int          wlast_beat;
  logic [31:0] rd_d [256];
  logic [1:0]  rd_r [256];
  logic        rd_l [256];
  int          rd_n;
  bit          rready_toggle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake never completed", name);
  endtask

  function automatic logic [31:0] word(input int i);
    return bank[32*i +: 32];
  endfunction

  task automatic aw_phase(input logic id, input logic [5:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int t;
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst;
    #1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); #1; t++; end
    if (!awready) timeout("aw_handshake");
    else begin @(posedge clk); #1; end
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input int nbeats, output int taken, output logic bv_early);
    int t;
    taken = 0;
    bv_early = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_beat);
      #1;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); #1; t++; end
      if (!wready) begin timeout("w_handshake"); break; end
      bv_early |= bvalid;
      @(posedge clk); #1;
      taken++;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic b_phase(output logic [1:0] resp, output logic id);
    int t;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); #1; t++; end
    resp = bresp;
    id   = bid;
    if (!bvalid) timeout("b_handshake");
    else begin @(posedge clk); #1; end
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output logic [1:0] resp, output int taken,
                           output logic bv_after, output logic wr_after);
    logic bv_early;
    logic id;
    aw_phase(1'b1, a, len, size, burst);
    w_phase(int'(len) + 1, taken, bv_early);
    bv_after = bvalid & ~bv_early;
    wr_after = wready;
    b_phase(resp, id);
  endtask

  task automatic ar_phase(input logic id, input logic [5:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int t;
    @(negedge clk);
    arvalid = 1'b1; arid = id; araddr = a; arlen = len; arsize = size; arburst = burst;
    #1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); #1; t++; end
    if (!arready) timeout("ar_handshake");
    else begin @(posedge clk); #1; end
    arvalid = 1'b0;
  endtask

  task automatic r_phase();
    int cyc;
    logic stalled;
    logic [31:0] hd;
    logic hl;
    logic [1:0] hr;
    rd_n = 0;
    stalled = 1'b0;
    hd = '0; hl = 1'b0; hr = '0;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rready = rready_toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (stalled) begin
        check("stall_rdata", rdata, hd);
        check("stall_rlast", {31'd0, rlast}, {31'd0, hl});
        check("stall_rresp", {30'd0, rresp}, {30'd0, hr});
      end
      stalled = rvalid && !rready;
      hd = rdata; hl = rlast; hr = rresp;
      if (rvalid && rready) begin
        rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast;
        rd_n++;
        if (rlast) break;
      end
    end
    if (cyc == 600) timeout("r_last");
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, output logic rv_first);
    ar_phase(1'b0, a, len, size, burst);
    rv_first = rvalid;
    r_phase();
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [1:0]  resp;
    logic        bv_after, wr_after, rv_first, id;
    int          taken;
    logic [31:0] exp8 [8];

    vecs[0]  = '{0, 6'h00, 3'd2, BURST_INCR,  32'h0,         4'hF,    32'h0,         RESP_OKAY};
    vecs[1]  = '{1, 6'h10, 3'd2, BURST_INCR,  32'h11223344,  4'hF,    32'h0,         RESP_OKAY};
    vecs[2]  = '{0, 6'h10, 3'd2, BURST_INCR,  32'h0,         4'hF,    32'h11223344,  RESP_OKAY};
    vecs[3]  = '{1, 6'h10, 3'd2, BURST_INCR,  32'hAABBCCDD,  4'b0011, 32'h0,         RESP_OKAY};
    vecs[4]  = '{0, 6'h10, 3'd2, BURST_INCR,  32'h0,         4'hF,    32'h1122CCDD,  RESP_OKAY};
    vecs[5]  = '{1, 6'h3C, 3'd2, BURST_INCR,  32'hDEADBEEF,  4'hF,    32'h0,         RESP_OKAY};
    vecs[6]  = '{0, 6'h3C, 3'd2, BURST_FIXED, 32'h0,         4'hF,    32'hDEADBEEF,  RESP_OKAY};
    vecs[7]  = '{1, 6'h14, 3'd1, BURST_INCR,  32'h12345678,  4'hF,    32'h0,         RESP_SLVERR};
    vecs[8]  = '{0, 6'h14, 3'd2, BURST_INCR,  32'h0,         4'hF,    32'h0,         RESP_OKAY};
    vecs[9]  = '{1, 6'h14, 3'd2, 2'b11,       32'h12345678,  4'hF,    32'h0,         RESP_SLVERR};
    vecs[10] = '{1, 6'h20, 3'd2, BURST_WRAP,  32'h77777777,  4'hF,    32'h0,         RESP_SLVERR};
    vecs[11] = '{0, 6'h20, 3'd2, BURST_INCR,  32'h0,         4'hF,    32'h0,         RESP_OKAY};
    vecs[12] = '{0, 6'h3C, 3'd1, BURST_INCR,  32'h0,         4'hF,    32'h0,         RESP_SLVERR};
    vecs[13] = '{1, 6'h17, 3'd2, BURST_INCR,  32'hA5A50000,  4'b1100, 32'h0,         RESP_OKAY};
    vecs[14] = '{0, 6'h14, 3'd2, BURST_INCR,  32'h0,         4'hF,    32'hA5A50000,  RESP_OKAY};
    vecs[15] = '{0, 6'h10, 3'd2, BURST_WRAP,  32'h0,         4'hF,    32'h0,         RESP_SLVERR};

    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    rready_toggle = 0; wlast_beat = 0;
    rst_n = 1'b0;
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_bank", {31'd0, |bank}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_awready", {31'd0, awready}, 32'd1);
    check("idle_rvalid_bvalid", {30'd0, rvalid, bvalid}, 32'd0);

    for (int v = 0; v < 16; v++) begin
      if (vecs[v].wr) begin
        wd[0] = vecs[v].wdata; ws[0] = vecs[v].strb; wlast_beat = 0;
        axi_write(vecs[v].addr, 8'd0, vecs[v].size, vecs[v].burst, resp, taken, bv_after, wr_after);
        check($sformatf("vec%0d_bresp", v), {30'd0, resp}, {30'd0, vecs[v].exp_resp});
      end else begin
        axi_read(vecs[v].addr, 8'd0, vecs[v].size, vecs[v].burst, rv_first);
        check($sformatf("vec%0d_rdata", v), rd_d[0], vecs[v].exp_data);
        check($sformatf("vec%0d_rresp", v), {30'd0, rd_r[0]}, {30'd0, vecs[v].exp_resp});
        check($sformatf("vec%0d_rlast", v), {31'd0, rd_l[0]}, 32'd1);
      end
    end

    // INCR 8-beat write of 1..8 at 0, then read back
    for (int i = 0; i < 8; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    wlast_beat = 7;
    aw_phase(1'b1, 6'h00, 8'd7, 3'd2, BURST_INCR);
    w_phase(8, taken, rv_first);
    check("incr_bvalid_early", {31'd0, rv_first}, 32'd0);
    check("incr_bvalid_next", {31'd0, bvalid}, 32'd1);
    b_phase(resp, id);
    check("incr_bresp", {30'd0, resp}, 32'd0);
    check("incr_bid", {31'd0, id}, 32'd1);
    for (int i = 0; i < 8; i++) check($sformatf("incr_bank%0d", i), word(i), i + 1);
    axi_read(6'h00, 8'd7, 3'd2, BURST_INCR, rv_first);
    check("incr_rvalid_first", {31'd0, rv_first}, 32'd1);
    check("incr_rbeats", rd_n, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("incr_rdata%0d", i), rd_d[i], i + 1);
      check($sformatf("incr_rlast%0d", i), {31'd0, rd_l[i]}, {31'd0, i == 7});
    end

    // WRAP 4-beat at 0x08
    wd[0] = 32'hAAAA0000; wd[1] = 32'hBBBB0000; wd[2] = 32'hCCCC0000; wd[3] = 32'hDDDD0000;
    wlast_beat = 3;
    axi_write(6'h08, 8'd3, 3'd2, BURST_WRAP, resp, taken, bv_after, wr_after);
    check("wrap_bresp", {30'd0, resp}, 32'd0);
    check("wrap_bank2", word(2), 32'hAAAA0000);
    check("wrap_bank3", word(3), 32'hBBBB0000);
    check("wrap_bank0", word(0), 32'hCCCC0000);
    check("wrap_bank1", word(1), 32'hDDDD0000);
    axi_read(6'h08, 8'd3, 3'd2, BURST_WRAP, rv_first);
    check("wrap_rd0", rd_d[0], 32'hAAAA0000);
    check("wrap_rd1", rd_d[1], 32'hBBBB0000);
    check("wrap_rd2", rd_d[2], 32'hCCCC0000);
    check("wrap_rd3", rd_d[3], 32'hDDDD0000);

    // Simultaneous AW and AR: write wins, read sees the new data
    @(negedge clk);
    awvalid = 1; awid = 0; awaddr = 6'h18; awlen = 0; awsize = 3'd2; awburst = BURST_INCR;
    arvalid = 1; arid = 1; araddr = 6'h18; arlen = 0; arsize = 3'd2; arburst = BURST_INCR;
    #1;
    check("sim_awready", {31'd0, awready}, 32'd1);
    check("sim_arready", {31'd0, arready}, 32'd0);
    @(posedge clk); #1;
    awvalid = 0;
    wd[0] = 32'h55556666; ws[0] = 4'hF; wlast_beat = 0;
    w_phase(1, taken, bv_after);
    check("sim_arready_wresp", {31'd0, arready}, 32'd0);
    b_phase(resp, id);
    ar_phase(1'b1, 6'h18, 8'd0, 3'd2, BURST_INCR);
    r_phase();
    check("sim_rdata", rd_d[0], 32'h55556666);

    // RREADY toggling over an 8-beat read
    exp8 = '{32'hCCCC0000, 32'hDDDD0000, 32'hAAAA0000, 32'hBBBB0000, 32'd5, 32'd6,
             32'h55556666, 32'd8};
    rready_toggle = 1;
    axi_read(6'h00, 8'd7, 3'd2, BURST_INCR, rv_first);
    rready_toggle = 0;
    check("tog_beats", rd_n, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tog_rdata%0d", i), rd_d[i], exp8[i]);
      check($sformatf("tog_rlast%0d", i), {31'd0, rd_l[i]}, {31'd0, i == 7});
    end

    // Illegal AWSIZE on a 2-beat burst leaves the bank alone
    wd[0] = 32'hBAD0BAD0; wd[1] = 32'hBAD1BAD1; ws[0] = 4'hF; ws[1] = 4'hF; wlast_beat = 1;
    axi_write(6'h28, 8'd1, 3'd1, BURST_INCR, resp, taken, bv_after, wr_after);
    check("size_bresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
    check("size_bank10", word(10), 32'd0);
    check("size_bank11", word(11), 32'd0);

    // Early WLAST on beat 3 of 8: all beats still taken and written
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h100 + i; ws[i] = 4'hF; end
    wlast_beat = 3;
    axi_write(6'h20, 8'd7, 3'd2, BURST_INCR, resp, taken, bv_after, wr_after);
    check("wlast_beats", taken, 32'd8);
    check("wlast_wready_after", {31'd0, wr_after}, 32'd0);
    check("wlast_bresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
    check("wlast_bank8", word(8), 32'h100);
    check("wlast_bank15", word(15), 32'h107);

    // INCR read wrapping off the top of the bank
    axi_read(6'h3C, 8'd1, 3'd2, BURST_INCR, rv_first);
    check("topwrap_rd0", rd_d[0], 32'h107);
    check("topwrap_rd1", rd_d[1], 32'hCCCC0000);

    // Illegal-read burst returns LEN+1 zero beats with SLVERR
    axi_read(6'h00, 8'd2, 3'd2, BURST_WRAP, rv_first);
    check("badrd_beats", rd_n, 32'd3);
    check("badrd_rdata2", rd_d[2], 32'd0);
    check("badrd_rresp2", {30'd0, rd_r[2]}, {30'd0, RESP_SLVERR});

    // Reset in the middle of a read
    ar_phase(1'b0, 6'h00, 8'd7, 3'd2, BURST_INCR);
    rready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    check("midrst_rlast_rdata", rdata | {31'd0, rlast}, 32'd0);
    check("midrst_bank", {31'd0, |bank}, 32'd0);
    rready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_awready", {31'd0, awready}, 32'd1);
    axi_read(6'h00, 8'd0, 3'd2, BURST_INCR, rv_first);
    check("postrst_rdata", rd_d[0], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
